// File: rtl/serial_operand_loader_pkg.sv
// Shared definitions for the serial operand loader and the adder it feeds.
// Holds the FSM state encoding and the default operand width.
package serial_operand_loader_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_A  = 2'd1,
        LOAD_B  = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Bit-counter width; never narrower than one bit so WIDTH=1 still works.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_operand_loader_shift_reg.sv
// Purpose: WIDTH-bit register written one indexed bit at a time, with a synchronous clear.
// Latency: a loaded bit appears on dat one cycle after load_en.
// Backpressure: none; the caller gates load_en.
module serial_shift_reg #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load_en,
    input  logic [CNT_W-1:0] bit_idx,
    input  logic             bit_in,
    output logic [WIDTH-1:0] dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat <= '0;
        end else if (clr) begin
            dat <= '0;
        end else if (load_en) begin
            dat[bit_idx] <= bit_in;
        end
    end

endmodule

// File: rtl/serial_operand_loader.sv
// Purpose: shift operands A then B in LSB first from a bit stream, present them to the adder, capture its result.
// Latency: with sin_valid held high, op_valid rises 2*WIDTH cycles after start; sum_valid pulses the cycle after op_ready.
// Backpressure: sin_valid=0 stalls loading; op_ready=0 holds PRESENT indefinitely with operands frozen.
module serial_operand_loader
    import serial_operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sin_valid,
    input  logic             sdata,
    output logic             busy,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic [WIDTH:0]   sum_in,
    output logic [WIDTH:0]   sum_out,
    output logic             sum_valid
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op_clr;
    logic             a_ld;
    logic             b_ld;
    logic             capture;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_clr    = 1'b0;
        a_ld      = 1'b0;
        b_ld      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // The start cycle never consumes a stream bit.
                if (start) begin
                    op_clr    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A: begin
                if (sin_valid) begin
                    a_ld = 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = '0;
                        state_nxt = LOAD_B;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (sin_valid) begin
                    b_ld = 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = '0;
                        state_nxt = PRESENT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (op_ready) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            op_valid  <= 1'b0;
            sum_valid <= 1'b0;
            sum_out   <= '0;
        end else begin
            busy      <= (state_nxt != IDLE);
            op_valid  <= (state_nxt == PRESENT);
            sum_valid <= capture;
            if (capture) begin
                sum_out <= sum_in;
            end
        end
    end

    serial_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (op_clr),
        .load_en (a_ld),
        .bit_idx (cnt),
        .bit_in  (sdata),
        .dat     (a_out)
    );

    serial_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (op_clr),
        .load_en (b_ld),
        .bit_idx (cnt),
        .bit_in  (sdata),
        .dat     (b_out)
    );

endmodule

// File: tb/tb_serial_operand_loader.sv
// Directed bench for serial_operand_loader: table of full transactions plus
// hand-written reset, hold and dropped-start-bit sequences.
module tb_serial_operand_loader;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sin_valid;
    logic             sdata;
    logic             busy;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH:0]   sum_out;
    logic             sum_valid;

    int passed;
    int total;

    serial_operand_loader #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sin_valid (sin_valid),
        .sdata     (sdata),
        .busy      (busy),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .sum_in    (sum_in),
        .sum_out   (sum_out),
        .sum_valid (sum_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]       stream;   // bit i is the i-th serial bit: A0,A1,A2,B0,B1,B2
        bit               toggle;   // insert a sin_valid=0 cycle after every bit
        bit               junk;     // sin_valid=1, sdata=1 in the start cycle
        bit               hold;     // stall in PRESENT before op_ready
        logic [WIDTH:0]   sum_drv;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        logic [WIDTH:0]   exp_sum;
    } vec_t;

    vec_t vecs[4];
    logic [WIDTH:0] prev_sum;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic load(input logic [5:0] s, input bit tog, input bit junk);
        start     = 1'b1;
        sin_valid = junk;
        sdata     = junk;
        @(negedge clk);
        start = 1'b0;
        chk("sum_valid_one_cycle", sum_valid, 0);
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("op_valid_before_last_bit", op_valid, 0);
            sin_valid = 1'b1;
            sdata     = s[i];
            @(negedge clk);
            if (tog) begin
                sin_valid = 1'b0;
                sdata     = ~s[i];
                @(negedge clk);
            end
        end
        sin_valid = 1'b0;
        sdata     = 1'b0;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        sin_valid = 1'b0;
        sdata     = 1'b0;
        op_ready  = 1'b0;
        sum_in    = '0;
        prev_sum  = '0;

        vecs[0] = '{6'b011101, 1'b0, 1'b0, 1'b0, 4'b1000, 3'b101, 3'b011, 4'd8};
        vecs[1] = '{6'b111111, 1'b1, 1'b0, 1'b1, 4'b1110, 3'b111, 3'b111, 4'd14};
        vecs[2] = '{6'b001000, 1'b0, 1'b0, 1'b0, 4'b0001, 3'b000, 3'b001, 4'd1};
        vecs[3] = '{6'b001110, 1'b0, 1'b1, 1'b0, 4'b0111, 3'b110, 3'b001, 4'd7};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_sum_out", sum_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in LOAD_B after A=101 and one B bit.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sin_valid = 1'b1;
        sdata = 1'b1; @(negedge clk);
        sdata = 1'b0; @(negedge clk);
        sdata = 1'b1; @(negedge clk);
        sdata = 1'b1; @(negedge clk);
        sin_valid = 1'b0;
        chk("partial_a_out", a_out, 3'b101);
        chk("partial_b_out", b_out, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("midload_rst_busy", busy, 0);
        chk("midload_rst_a_out", a_out, 0);
        chk("midload_rst_b_out", b_out, 0);
        chk("midload_rst_op_valid", op_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midload_no_capture", sum_valid, 0);

        // Consecutive transactions; each new start lands in the sum_valid cycle of the previous one.
        for (int v = 0; v < 4; v++) begin
            load(vecs[v].stream, vecs[v].toggle, vecs[v].junk);
            chk("op_valid", op_valid, 1);
            chk("busy_present", busy, 1);
            chk("a_out", a_out, vecs[v].exp_a);
            chk("b_out", b_out, vecs[v].exp_b);
            if (vecs[v].hold) begin
                for (int k = 0; k < 5; k++) begin
                    start     = (k % 2 == 0);
                    sin_valid = (k % 2 == 1);
                    sdata     = 1'b0;
                    @(negedge clk);
                    chk("hold_op_valid", op_valid, 1);
                    chk("hold_sum_valid", sum_valid, 0);
                end
                start     = 1'b0;
                sin_valid = 1'b0;
                chk("hold_a_out", a_out, vecs[v].exp_a);
                chk("hold_b_out", b_out, vecs[v].exp_b);
            end
            chk("sum_out_kept", sum_out, prev_sum);
            sum_in   = vecs[v].sum_drv;
            op_ready = 1'b1;
            @(negedge clk);
            op_ready = 1'b0;
            sum_in   = '0;
            chk("sum_valid", sum_valid, 1);
            chk("sum_out", sum_out, vecs[v].exp_sum);
            chk("op_valid_drop", op_valid, 0);
            chk("busy_idle", busy, 0);
            prev_sum = vecs[v].exp_sum;
        end

        @(negedge clk);
        chk("final_sum_valid_low", sum_valid, 0);
        chk("final_sum_out_hold", sum_out, 4'd7);
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_operand_loader.md
Name: serial_operand_loader

Overview:
- Bit-serial front end for the 3-bit parallel adder stage (paradd).
- Shifts in operand A, then operand B, LSB first, from a 1-bit stream, and presents both operands in parallel to the adder under a valid/ready handshake.
- Captures the adder's WIDTH+1-bit result (carry is the MSB) into a registered output and pulses sum_valid.
- Sits directly upstream of the adder; the adder stays purely combinational between a_out/b_out and sum_in.

Parameters:
- WIDTH, 3, operand width in bits; must match the adder width.
- CNT_W, $clog2(WIDTH) (min 1), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a new load; honoured only in IDLE.
- sin_valid  input  1  sdata holds a valid bit this cycle.
- sdata  input  1  serial operand bit, LSB first, A then B.
- busy  output  1  high in any state other than IDLE.
- a_out  output  WIDTH  operand A to adder (a1..a3).
- b_out  output  WIDTH  operand B to adder (b1..b3).
- op_valid  output  1  a_out/b_out are complete and stable.
- op_ready  input  1  adder result on sum_in is valid this cycle.
- sum_in  input  WIDTH+1  adder result; bit WIDTH is the carry out.
- sum_out  output  WIDTH+1  registered captured result.
- sum_valid  output  1  one-cycle pulse when sum_out updates.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cnt=0.
  - a_out, b_out, sum_out = 0.
  - op_valid, sum_valid, busy = 0.
  - Reset mid-load or mid-PRESENT abandons the transfer; nothing is captured.
- All outputs are registered; state changes on the rising clk edge.
- FSM states: IDLE, LOAD_A, LOAD_B, PRESENT.
- IDLE:
  - start=1 -> clear a_out and b_out to 0, set cnt=0, go to LOAD_A.
  - sdata is not consumed in the start cycle, even if sin_valid=1.
- LOAD_A:
  - Each cycle with sin_valid=1: a_out[cnt] <= sdata, then cnt increments.
  - When cnt=WIDTH-1 is accepted: cnt <= 0, go to LOAD_B.
  - sin_valid=0 stalls; state and cnt hold.
- LOAD_B:
  - Identical to LOAD_A, writing b_out[cnt].
  - On the last bit, go to PRESENT.
- PRESENT:
  - op_valid=1; a_out and b_out are frozen.
  - op_ready=1 -> sum_out <= sum_in, sum_valid=1 for the next cycle only, op_valid drops, go to IDLE.
  - op_ready=0 holds indefinitely.
- Ignored inputs:
  - start is ignored in LOAD_A, LOAD_B and PRESENT.
  - sin_valid/sdata are ignored in IDLE and PRESENT.
- Latency with sin_valid held high: start accepted at edge 0; bits accepted at edges 1..2*WIDTH; op_valid high after edge 2*WIDTH (edge 6 for WIDTH=3).
- Back-to-back: start may be asserted in the cycle sum_valid is high (state is already IDLE) and is accepted.
- sum_out holds its value until the next capture or reset.
- a_out and b_out are only meaningful while op_valid=1; during loading they show the partial contents.
- Width rule: sum_in is unsigned; the full range 0..2*(2^WIDTH-1) is captured without truncation (max 14 for WIDTH=3).

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LOAD_A=2'd1, LOAD_B=2'd2, PRESENT=2'd3) and the default WIDTH=3, so the adder wrapper and this block agree on width.
- One natural sub-module: serial_shift_reg. It holds the WIDTH-bit indexed-bit loader (clear, load-enable, bit index), and is instantiated twice, once for A and once for B.
- FSM and counter stay in the top level.

Test Plan:
- Reset during LOAD_B (after A=101 and one B bit) -> all outputs 0, state IDLE; the next start loads cleanly.
- start, then sdata 1,0,1,1,1,0 with sin_valid=1 continuous -> after edge 6, op_valid=1, a_out=3'b101, b_out=3'b011. Drive sum_in=4'b1000 with op_ready=1 -> sum_out=8 and sum_valid high exactly one cycle.
- A=111, B=111 with sin_valid toggled 1,0 per cycle -> loading takes twice as many cycles, operands are still correct, and sum_in=4'b1110 is captured as sum_out=14.
- In PRESENT, op_ready held 0 for 5 cycles while start and sin_valid toggle -> op_valid stays 1, a_out/b_out are unchanged, and no capture occurs.
- Back-to-back: start asserted in the sum_valid cycle, then A=000, B=001 -> the second transaction yields a_out=0, b_out=1. sum_out keeps its previous value until the second op_ready.
- start and sin_valid=1 with sdata=1 in the same IDLE cycle -> that bit is dropped; a_out[0] takes the next accepted bit.
